miner_job_scheduler: RTL and testbench
======================================

# miner_job_scheduler

Job-level controller for a bank of `NUM_CORES` SHA-256d miner cores.
- Accepts one mining job: midstate, 96-bit tail data and an inclusive nonce range.
- Splits the range into equal per-core slices and launches every core with a one-cycle reset pulse.
- Tracks each core with a cycle-budget timer, collects golden nonces through a round-robin result port, and relaunches a core past its find until its slice is exhausted.
- Sits between the host command decoder and the miner cores.

## Interface
Parameters:
- `NUM_CORES`, 4: number of miner cores; power of two, 1..16.
- `LOOP_LOG2`, 5: must match the cores; one nonce per 2^LOOP_LOG2 cycles.
- `DRAIN_CYCLES`, 160: extra cycles added to every budget to cover pipeline latency.

Ports (clock and reset first):
- `hash_clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `job_valid`  in  1  job offer.
- `job_ready`  out  1  high only in IDLE.
- `job_midstate`  in  256  midstate.
- `job_data`  in  96  block tail.
- `job_nonce_start`  in  32  first nonce, inclusive.
- `job_nonce_end`  in  32  last nonce, inclusive; must be ≥ start.
- `abort`  in  1  drop the current job.
- `core_reset`  out  NUM_CORES  per-core launch pulse.
- `core_midstate`  out  256  registered job midstate; shared by all cores.
- `core_data`  out  96  registered job data; shared by all cores.
- `core_nonce_min`  out  32*NUM_CORES  per-core slice start.
- `core_nonce_max`  out  32*NUM_CORES  per-core slice end.
- `core_golden_nonce`  in  32*NUM_CORES  per-core found nonce.
- `core_new_golden`  in  NUM_CORES  per-core found flag.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumer ready.
- `res_nonce`  out  32  found nonce.
- `res_core`  out  4  index of the core that found it.
- `job_done`  out  1  one-cycle pulse at job completion.
- `busy`  out  1  high whenever not in IDLE.

## Operation
FSM states: IDLE, SPLIT, LAUNCH, RUN, DONE.
- **IDLE:**
  - `job_ready`=1.
  - On `job_valid` the job is registered and the FSM goes to SPLIT.
- **SPLIT:**
  - N = span+1 = end−start+1, computed as 33-bit.
  - len = N >> log2(NUM_CORES).
  - Core k: min = start + k·len, max = min + len − 1.
  - The last core's max is forced to `end`.
  - If len==0, core 0 gets the full range and all other cores are marked done.
- **LAUNCH:**
  - Assert `core_reset` for every non-done core for exactly one cycle.
  - Load each such core's timer with ((max−min+1) << LOOP_LOG2) + DRAIN_CYCLES; timer width is 33+LOOP_LOG2+8 bits.
  - Then go to RUN.
- **RUN, per-core sub-state ACTIVE / PENDING / DONE:**
  - **ACTIVE:**
    - The timer decrements every cycle.
    - Timer reaching 0 moves the core to DONE.
    - A rising edge of `core_new_golden[k]` (edge detector per core; the level is ignored) captures the nonce into a per-core slot and moves the core to PENDING.
  - **PENDING:**
    - The timer is frozen.
    - When the slot is accepted on the result port, there are two cases.
    - If the captured nonce < max: min ← nonce+1, the timer is reloaded from the new min, `core_reset[k]` pulses one cycle, and the core returns to ACTIVE.
    - Otherwise the core goes to DONE.
  - **FSM exit:** all cores DONE with no pending slots → DONE.
- **DONE:** pulse `job_done` one cycle, then IDLE.
- **Result port:**
  - Round-robin over PENDING slots; the pointer advances past the granted core.
  - `res_*` stay stable while `res_valid` && !`res_ready`.
- **abort:**
  - In any non-IDLE state the FSM goes to IDLE on the next edge.
  - All slots are cleared, no `job_done` pulse, no `core_reset`.
  - Golden edges arriving in IDLE are ignored.
- **Simultaneous events:**
  - A golden edge in the same cycle the timer hits 0: the golden edge wins (PENDING).
  - abort outranks everything.
- **Arithmetic:** all nonce math is modulo 2^32. An end of 0xFFFFFFFF gives N=2^32, which must not wrap to 0.

## Timing
- **Reset values:**
  - FSM in IDLE; `job_ready`=1.
  - `busy`, `res_valid`, `job_done`, `core_reset` = 0.
  - All data outputs and `res_core` = 0.
- **Launch latency:** handshake at cycle T → SPLIT at T+1 → `core_reset` high during T+2 → RUN at T+3.
- **Result latency:** `core_new_golden` rises at cycle C → `res_valid` at C+1 at the earliest.
- **Relaunch:** `core_reset` pulses in the cycle after the result is accepted.
- **Stability:** `core_midstate`, `core_data`, min and max stay stable from LAUNCH until the next job.
- **Completion:** `job_done` asserts the cycle after the last core reaches DONE.

## Structure
- Package `miner_pkg` holds the FSM state enum, the per-core state enum, and the timer-width localparam.
- One sub-module `rr_arbiter` (NUM_CORES-wide request/grant with a rotating pointer) serves the result port.

## Test plan
- **Basic split:** NUM_CORES=4, range 0x0000_0000..0x0000_03FF, no finds → mins 0,0x100,0x200,0x300 and max 0x3FF on core 3; `job_done` exactly (0x100<<5)+160 cycles after the launch cycle (whose timer load counts as cycle 0).
- **Find and resume:**
  - Core 1 reports 0x150 → `res_nonce`=0x150, `res_core`=1.
  - After `res_ready`, core 1 relaunches with min 0x151, max 0x1FF.
- **Back-pressure:**
  - Cores 0 and 2 find in the same cycle with `res_ready`=0 for 10 cycles.
  - Outputs hold; grants then go 0 then 2, and neither core relaunches before its own grant.
- **Small range:** 0x10..0x11 with 4 cores → only core 0 is launched, with min 0x10 and max 0x11.
- **Full range:** 0x0..0xFFFFFFFF → core 3 max is 0xFFFFFFFF and the timer does not wrap to 0.
- **Abort:**
  - Assert `abort` mid-RUN → IDLE next cycle, `job_ready`=1, no `job_done`.
  - A later golden edge produces no `res_valid`.
  - Async `reset` mid-RUN clears all outputs immediately.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types for the miner job scheduler: top-level FSM states, per-core
// run states and the fixed part of the per-core budget timer width.
package miner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPLIT,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE
    } sched_st_e;

    typedef enum logic [1:0] {
        CS_ACTIVE,
        CS_PENDING,
        CS_DONE
    } core_st_e;

    // 33-bit slice length plus 8 bits of drain headroom; the top adds LOOP_LOG2.
    localparam int TIMER_W_BASE = 33 + 8;

endpackage

// File: rtl/miner_job_scheduler_rr_arbiter.sv
// Round-robin selector over pending result slots. A grant offered while the
// consumer is stalled is locked so the result port never changes mid-offer.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          hash_clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [N-1:0]  req,
    input  logic          ready,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] lock_idx_q, lock_idx_d;
    logic          lock_q, lock_d;
    logic [IW-1:0] pick, idx;
    logic          found;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = ptr_q + IW'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        gnt_valid = |req;
        gnt_idx   = lock_q ? lock_idx_q : pick;

        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (flush) begin
            ptr_d  = '0;
            lock_d = 1'b0;
        end else if (gnt_valid && ready) begin
            ptr_d  = (N == 1) ? '0 : gnt_idx + IW'(1);
            lock_d = 1'b0;
        end else if (gnt_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_idx;
        end
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: rtl/miner_job_scheduler.sv
// Job-level controller: splits a nonce range over NUM_CORES miner cores,
// budgets each core with a down-counter and funnels golden nonces out.
//   state  | meaning
//   IDLE   | waiting for a job, job_ready high
//   SPLIT  | compute per-core slices
//   LAUNCH | core_reset pulse active, budgets loaded
//   RUN    | cores mining, results collected
//   DONE   | one-cycle job_done pulse
module miner_job_scheduler
    import miner_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int LOOP_LOG2    = 5,
    parameter int DRAIN_CYCLES = 160
) (
    input  logic                    hash_clk,
    input  logic                    reset,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [255:0]            job_midstate,
    input  logic [95:0]             job_data,
    input  logic [31:0]             job_nonce_start,
    input  logic [31:0]             job_nonce_end,
    input  logic                    abort,
    output logic [NUM_CORES-1:0]    core_reset,
    output logic [255:0]            core_midstate,
    output logic [95:0]             core_data,
    output logic [32*NUM_CORES-1:0] core_nonce_min,
    output logic [32*NUM_CORES-1:0] core_nonce_max,
    input  logic [32*NUM_CORES-1:0] core_golden_nonce,
    input  logic [NUM_CORES-1:0]    core_new_golden,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [31:0]             res_nonce,
    output logic [3:0]              res_core,
    output logic                    job_done,
    output logic                    busy
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int LG = $clog2(NUM_CORES);
    localparam int TW = TIMER_W_BASE + LOOP_LOG2;

    sched_st_e             state_q, state_d;
    logic [255:0]          midstate_q, midstate_d;
    logic [95:0]           data_q, data_d;
    logic [31:0]           start_q, start_d, end_q, end_d;
    logic [31:0]           min_q [NUM_CORES];
    logic [31:0]           min_d [NUM_CORES];
    logic [31:0]           max_q [NUM_CORES];
    logic [31:0]           max_d [NUM_CORES];
    logic [31:0]           slot_q [NUM_CORES];
    logic [31:0]           slot_d [NUM_CORES];
    logic [TW-1:0]         timer_q [NUM_CORES];
    logic [TW-1:0]         timer_d [NUM_CORES];
    core_st_e              cst_q [NUM_CORES];
    core_st_e              cst_d [NUM_CORES];
    logic [NUM_CORES-1:0]  gold_prev_q, gold_edge, pend;
    logic [NUM_CORES-1:0]  core_reset_q, core_reset_d;
    logic [32:0]           span_n, len;
    logic [31:0]           len32, acc;
    logic                  all_done, accept, flush, gnt_valid;
    logic [IW-1:0]         gnt_idx;

    // Load value counts the launch/relaunch cycle itself as the first budget cycle.
    function automatic logic [TW-1:0] budget(input logic [31:0] lo, input logic [31:0] hi);
        logic [32:0] n;
        n = {1'b0, hi} - {1'b0, lo} + 33'd1;
        return (TW'(n) << LOOP_LOG2) + TW'(DRAIN_CYCLES) - TW'(1);
    endfunction

    assign gold_edge = core_new_golden & ~gold_prev_q;
    assign accept    = gnt_valid && res_ready;
    assign flush     = (abort && state_q != ST_IDLE) || (state_q == ST_IDLE && job_valid);

    always_comb begin
        for (int k = 0; k < NUM_CORES; k++) pend[k] = (cst_q[k] == CS_PENDING);
    end

    rr_arbiter #(.N(NUM_CORES), .IW(IW)) u_rr (
        .hash_clk  (hash_clk),
        .reset     (reset),
        .flush     (flush),
        .req       (pend),
        .ready     (res_ready),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        span_n       = {1'b0, end_q} - {1'b0, start_q} + 33'd1;
        len          = span_n >> LG;
        len32        = len[31:0];
        acc          = start_q;
        all_done     = 1'b0;
        state_d      = state_q;
        midstate_d   = midstate_q;
        data_d       = data_q;
        start_d      = start_q;
        end_d        = end_q;
        core_reset_d = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            min_d[k]   = min_q[k];
            max_d[k]   = max_q[k];
            slot_d[k]  = slot_q[k];
            timer_d[k] = timer_q[k];
            cst_d[k]   = cst_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    midstate_d = job_midstate;
                    data_d     = job_data;
                    start_d    = job_nonce_start;
                    end_d      = job_nonce_end;
                    state_d    = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                for (int k = 0; k < NUM_CORES; k++) begin
                    slot_d[k] = '0;
                    if (len == 33'd0) begin
                        min_d[k]        = (k == 0) ? start_q : '0;
                        max_d[k]        = (k == 0) ? end_q : '0;
                        cst_d[k]        = (k == 0) ? CS_ACTIVE : CS_DONE;
                        core_reset_d[k] = (k == 0);
                    end else begin
                        min_d[k]        = acc;
                        max_d[k]        = (k == NUM_CORES - 1) ? end_q : acc + len32 - 32'd1;
                        cst_d[k]        = CS_ACTIVE;
                        core_reset_d[k] = 1'b1;
                        acc             = acc + len32;
                    end
                end
                state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                for (int k = 0; k < NUM_CORES; k++) begin
                    if (cst_q[k] == CS_ACTIVE) timer_d[k] = budget(min_q[k], max_q[k]);
                end
                state_d = ST_RUN;
            end
            ST_RUN: begin
                all_done = 1'b1;
                for (int k = 0; k < NUM_CORES; k++) begin
                    case (cst_q[k])
                        CS_ACTIVE: begin
                            if (gold_edge[k]) begin
                                slot_d[k] = core_golden_nonce[32*k +: 32];
                                cst_d[k]  = CS_PENDING;
                            end else if (timer_q[k] <= TW'(1)) begin
                                timer_d[k] = '0;
                                cst_d[k]   = CS_DONE;
                            end else begin
                                timer_d[k] = timer_q[k] - TW'(1);
                            end
                        end
                        CS_PENDING: begin
                            if (accept && gnt_idx == IW'(k)) begin
                                if (slot_q[k] < max_q[k]) begin
                                    min_d[k]        = slot_q[k] + 32'd1;
                                    timer_d[k]      = budget(slot_q[k] + 32'd1, max_q[k]);
                                    core_reset_d[k] = 1'b1;
                                    cst_d[k]        = CS_ACTIVE;
                                end else begin
                                    cst_d[k] = CS_DONE;
                                end
                            end
                        end
                        default: ;
                    endcase
                    all_done = all_done && (cst_d[k] == CS_DONE);
                end
                if (all_done) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (abort && state_q != ST_IDLE) begin
            state_d      = ST_IDLE;
            core_reset_d = '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                cst_d[k]  = CS_DONE;
                slot_d[k] = '0;
            end
        end
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            midstate_q   <= '0;
            data_q       <= '0;
            start_q      <= '0;
            end_q        <= '0;
            gold_prev_q  <= '0;
            core_reset_q <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                min_q[k]   <= '0;
                max_q[k]   <= '0;
                slot_q[k]  <= '0;
                timer_q[k] <= '0;
                cst_q[k]   <= CS_DONE;
            end
        end else begin
            state_q      <= state_d;
            midstate_q   <= midstate_d;
            data_q       <= data_d;
            start_q      <= start_d;
            end_q        <= end_d;
            gold_prev_q  <= core_new_golden;
            core_reset_q <= core_reset_d;
            for (int k = 0; k < NUM_CORES; k++) begin
                min_q[k]   <= min_d[k];
                max_q[k]   <= max_d[k];
                slot_q[k]  <= slot_d[k];
                timer_q[k] <= timer_d[k];
                cst_q[k]   <= cst_d[k];
            end
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_flat
        assign core_nonce_min[32*g +: 32] = min_q[g];
        assign core_nonce_max[32*g +: 32] = max_q[g];
    end

    assign core_reset    = core_reset_q;
    assign core_midstate = midstate_q;
    assign core_data     = data_q;
    assign res_valid     = gnt_valid;
    assign res_core      = gnt_valid ? 4'(gnt_idx) : 4'd0;
    assign res_nonce     = gnt_valid ? slot_q[gnt_idx] : 32'd0;
    assign job_done      = (state_q == ST_DONE);
    assign busy          = (state_q != ST_IDLE);
    assign job_ready     = (state_q == ST_IDLE);

endmodule

// File: tb/tb_miner_job_scheduler.sv
// Directed bench for miner_job_scheduler with NUM_CORES=4, LOOP_LOG2=5,
// DRAIN_CYCLES=160; expected values are hand-computed constants.
module tb_miner_job_scheduler;

    logic          hash_clk = 1'b0;
    logic          reset;
    logic          job_valid;
    logic          job_ready;
    logic [255:0]  job_midstate;
    logic [95:0]   job_data;
    logic [31:0]   job_nonce_start;
    logic [31:0]   job_nonce_end;
    logic          abort;
    logic [3:0]    core_reset;
    logic [255:0]  core_midstate;
    logic [95:0]   core_data;
    logic [127:0]  core_nonce_min;
    logic [127:0]  core_nonce_max;
    logic [127:0]  core_golden_nonce;
    logic [3:0]    core_new_golden;
    logic          res_valid;
    logic          res_ready;
    logic [31:0]   res_nonce;
    logic [3:0]    res_core;
    logic          job_done;
    logic          busy;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 hash_clk = ~hash_clk;

    miner_job_scheduler #(.NUM_CORES(4), .LOOP_LOG2(5), .DRAIN_CYCLES(160)) dut (
        .hash_clk          (hash_clk),
        .reset             (reset),
        .job_valid         (job_valid),
        .job_ready         (job_ready),
        .job_midstate      (job_midstate),
        .job_data          (job_data),
        .job_nonce_start   (job_nonce_start),
        .job_nonce_end     (job_nonce_end),
        .abort             (abort),
        .core_reset        (core_reset),
        .core_midstate     (core_midstate),
        .core_data         (core_data),
        .core_nonce_min    (core_nonce_min),
        .core_nonce_max    (core_nonce_max),
        .core_golden_nonce (core_golden_nonce),
        .core_new_golden   (core_new_golden),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_nonce         (res_nonce),
        .res_core          (res_core),
        .job_done          (job_done),
        .busy              (busy)
    );

    // Returns at the negedge of the launch cycle (core_reset expected high).
    task automatic launch_job(input logic [31:0] s, input logic [31:0] e);
        @(negedge hash_clk);
        job_valid       = 1'b1;
        job_nonce_start = s;
        job_nonce_end   = e;
        @(negedge hash_clk);
        job_valid = 1'b0;
        @(negedge hash_clk);
    endtask

    task automatic do_abort();
        @(negedge hash_clk);
        abort = 1'b1;
        @(negedge hash_clk);
        abort = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({job_ready, busy, res_valid, job_done, core_reset} !== 8'b1000_0000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want %b", {job_ready, busy, res_valid, job_done, core_reset}, 8'b1000_0000);
        end
        tests_run++;
        if ({core_midstate, core_data, core_nonce_min, core_nonce_max, res_nonce, res_core} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got nonzero data outputs want all zero");
        end
        @(negedge hash_clk);
        reset = 1'b0;
        @(negedge hash_clk);
        tests_run++;
        if ({job_ready, busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got %b want 10", {job_ready, busy});
        end
    endtask

    task automatic test_basic_split();
        int first = -1;
        int pulses = 0;
        int stray_reset = 0;
        job_midstate = {8{32'hC0DE_1234}};
        job_data     = {3{32'h5A5A_0F0F}};
        @(negedge hash_clk);
        job_valid       = 1'b1;
        job_nonce_start = 32'h0;
        job_nonce_end   = 32'h3FF;
        @(negedge hash_clk);
        job_valid = 1'b0;
        tests_run++;
        if ({job_ready, busy, core_reset} !== 6'b01_0000) begin
            tests_failed++;
            $display("FAIL split_cycle: got %b want 010000", {job_ready, busy, core_reset});
        end
        @(negedge hash_clk);
        tests_run++;
        if (core_reset !== 4'b1111) begin
            tests_failed++;
            $display("FAIL launch_reset: got %b want 1111", core_reset);
        end
        tests_run++;
        if (core_nonce_min !== {32'h300, 32'h200, 32'h100, 32'h0}) begin
            tests_failed++;
            $display("FAIL split_min: got %h want %h", core_nonce_min, {32'h300, 32'h200, 32'h100, 32'h0});
        end
        tests_run++;
        if (core_nonce_max !== {32'h3FF, 32'h2FF, 32'h1FF, 32'hFF}) begin
            tests_failed++;
            $display("FAIL split_max: got %h want %h", core_nonce_max, {32'h3FF, 32'h2FF, 32'h1FF, 32'hFF});
        end
        tests_run++;
        if ({core_midstate, core_data} !== {{8{32'hC0DE_1234}}, {3{32'h5A5A_0F0F}}}) begin
            tests_failed++;
            $display("FAIL job_regs: got %h want %h", {core_midstate, core_data}, {{8{32'hC0DE_1234}}, {3{32'h5A5A_0F0F}}});
        end
        // (0x100 << 5) + 160 = 8352 cycles after the launch cycle.
        for (int i = 1; i <= 8356; i++) begin
            @(negedge hash_clk);
            if (job_done) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (core_reset !== 4'b0000) stray_reset++;
        end
        tests_run++;
        if (first !== 8352) begin
            tests_failed++;
            $display("FAIL done_latency: got %0d want %0d", first, 8352);
        end
        tests_run++;
        if (pulses !== 1) begin
            tests_failed++;
            $display("FAIL done_pulse_width: got %0d want 1", pulses);
        end
        tests_run++;
        if ({stray_reset, job_ready} !== {32'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL after_done: got stray=%0d ready=%b want 0 1", stray_reset, job_ready);
        end
    endtask

    task automatic test_find_resume();
        launch_job(32'h0, 32'h3FF);
        repeat (20) @(negedge hash_clk);
        core_golden_nonce[32*1 +: 32] = 32'h150;
        core_new_golden[1]            = 1'b1;
        @(negedge hash_clk);
        tests_run++;
        if ({res_valid, res_core, res_nonce} !== {1'b1, 4'd1, 32'h150}) begin
            tests_failed++;
            $display("FAIL find_result: got %b %h %h want 1 1 150", res_valid, res_core, res_nonce);
        end
        res_ready = 1'b1;
        @(negedge hash_clk);
        res_ready = 1'b0;
        tests_run++;
        if ({core_reset, res_valid} !== 5'b0010_0) begin
            tests_failed++;
            $display("FAIL relaunch_pulse: got %b want 00100", {core_reset, res_valid});
        end
        tests_run++;
        if ({core_nonce_min[63:32], core_nonce_max[63:32]} !== {32'h151, 32'h1FF}) begin
            tests_failed++;
            $display("FAIL relaunch_slice: got %h %h want 151 1ff", core_nonce_min[63:32], core_nonce_max[63:32]);
        end
        core_new_golden[1] = 1'b0;
        do_abort();
    endtask

    task automatic test_back_pressure();
        int bad = 0;
        launch_job(32'h0, 32'h3FF);
        repeat (10) @(negedge hash_clk);
        core_golden_nonce[31:0]  = 32'h10;
        core_golden_nonce[95:64] = 32'h250;
        core_new_golden          = 4'b0101;
        res_ready                = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge hash_clk);
            if ({res_valid, res_core, res_nonce, core_reset} !== {1'b1, 4'd0, 32'h10, 4'b0000}) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        res_ready = 1'b1;
        @(negedge hash_clk);
        tests_run++;
        if ({res_valid, res_core, res_nonce, core_reset} !== {1'b1, 4'd2, 32'h250, 4'b0001}) begin
            tests_failed++;
            $display("FAIL bp_second: got %b %h %h %b want 1 2 250 0001", res_valid, res_core, res_nonce, core_reset);
        end
        @(negedge hash_clk);
        res_ready = 1'b0;
        tests_run++;
        if ({res_valid, core_reset, core_nonce_min[95:64], core_nonce_min[31:0]} !== {1'b0, 4'b0100, 32'h251, 32'h11}) begin
            tests_failed++;
            $display("FAIL bp_relaunch: got %b %b %h %h want 0 0100 251 11", res_valid, core_reset, core_nonce_min[95:64], core_nonce_min[31:0]);
        end
        core_new_golden = 4'b0000;
        do_abort();
    endtask

    task automatic test_small_range();
        int first = -1;
        launch_job(32'h10, 32'h11);
        tests_run++;
        if ({core_reset, core_nonce_min[31:0], core_nonce_max[31:0]} !== {4'b0001, 32'h10, 32'h11}) begin
            tests_failed++;
            $display("FAIL small_launch: got %b %h %h want 0001 10 11", core_reset, core_nonce_min[31:0], core_nonce_max[31:0]);
        end
        // (2 << 5) + 160 = 224
        for (int i = 1; i <= 230; i++) begin
            @(negedge hash_clk);
            if (job_done && first < 0) first = i;
        end
        tests_run++;
        if (first !== 224) begin
            tests_failed++;
            $display("FAIL small_done: got %0d want 224", first);
        end
    endtask

    task automatic test_full_range();
        int early = 0;
        launch_job(32'h0, 32'hFFFF_FFFF);
        tests_run++;
        if (core_nonce_min !== {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0}) begin
            tests_failed++;
            $display("FAIL full_min: got %h", core_nonce_min);
        end
        tests_run++;
        if (core_nonce_max !== {32'hFFFF_FFFF, 32'hBFFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF}) begin
            tests_failed++;
            $display("FAIL full_max: got %h", core_nonce_max);
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge hash_clk);
            if (job_done || !busy) early++;
        end
        tests_run++;
        if (early !== 0) begin
            tests_failed++;
            $display("FAIL full_no_wrap: got %0d early-done cycles want 0", early);
        end
        do_abort();
    endtask

    task automatic test_abort();
        int spurious = 0;
        launch_job(32'h0, 32'h3FF);
        repeat (10) @(negedge hash_clk);
        core_golden_nonce[63:32] = 32'h123;
        core_new_golden[1]       = 1'b1;
        @(negedge hash_clk);
        tests_run++;
        if (res_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_pre_result: got %b want 1", res_valid);
        end
        abort = 1'b1;
        @(negedge hash_clk);
        abort = 1'b0;
        tests_run++;
        if ({job_ready, busy, res_valid, job_done, core_reset} !== 8'b1000_0000) begin
            tests_failed++;
            $display("FAIL abort_idle: got %b want 10000000", {job_ready, busy, res_valid, job_done, core_reset});
        end
        core_new_golden[1] = 1'b0;
        repeat (3) begin
            @(negedge hash_clk);
            if (job_done || core_reset !== 4'b0000) spurious++;
        end
        core_golden_nonce[127:96] = 32'h777;
        core_new_golden[3]        = 1'b1;
        repeat (4) begin
            @(negedge hash_clk);
            if (res_valid || job_done) spurious++;
        end
        core_new_golden[3] = 1'b0;
        tests_run++;
        if (spurious !== 0) begin
            tests_failed++;
            $display("FAIL abort_quiet: got %0d spurious cycles want 0", spurious);
        end
    endtask

    task automatic test_async_reset();
        job_midstate = {8{32'h1111_2222}};
        job_data     = {3{32'h3333_4444}};
        launch_job(32'h100, 32'h4FF);
        repeat (5) @(negedge hash_clk);
        core_golden_nonce[95:64] = 32'h300;
        core_new_golden[2]       = 1'b1;
        @(negedge hash_clk);
        tests_run++;
        if ({res_valid, busy} !== 2'b11) begin
            tests_failed++;
            $display("FAIL arst_pre: got %b want 11", {res_valid, busy});
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({job_ready, busy, res_valid, job_done, core_reset, res_core, res_nonce} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, 32'b0}) begin
            tests_failed++;
            $display("FAIL arst_ctrl: got %b %b %b %b %b %h %h want 1 0 0 0 0 0 0", job_ready, busy, res_valid, job_done, core_reset, res_core, res_nonce);
        end
        tests_run++;
        if ({core_midstate, core_data, core_nonce_min, core_nonce_max} !== '0) begin
            tests_failed++;
            $display("FAIL arst_data: got nonzero data outputs want all zero");
        end
        core_new_golden = 4'b0000;
        @(negedge hash_clk);
        reset = 1'b0;
        @(negedge hash_clk);
    endtask

    initial begin
        reset             = 1'b1;
        job_valid         = 1'b0;
        job_midstate      = '0;
        job_data          = '0;
        job_nonce_start   = '0;
        job_nonce_end     = '0;
        abort             = 1'b0;
        core_golden_nonce = '0;
        core_new_golden   = '0;
        res_ready         = 1'b0;
        repeat (2) @(negedge hash_clk);

        test_reset();
        test_basic_split();
        test_find_resume();
        test_back_pressure();
        test_small_range();
        test_full_range();
        test_abort();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
